mod_exp_unit: RTL and testbench

MOD_EXP_UNIT -- requirements
Module: mod_exp_unit

---
 rtl/rsa_pkg.sv | 11 +
 rtl/mod_mul.sv | 17 +
 rtl/mod_exp_unit.sv | 119 +++++++++++
 tb/tb_mod_exp_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath stages (mod-exp, CRT, inverse).
package rsa_pkg;
  localparam int RSA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/mod_mul.sv
// Combinational modular product: full 2W-bit product reduced by a 2W-by-W modulo.
module mod_mul #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_p
);
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_n_ext;

  assign w_prod  = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  assign w_n_ext = {{W{1'b0}}, i_n};
  // A zero modulus yields 0 rather than an undefined remainder.
  assign o_p = (i_n == '0) ? '0 : W'(w_prod % w_n_ext);
endmodule

// File: rtl/mod_exp_unit.sv
// Right-to-left square-and-multiply modular exponentiation, one exponent bit per cycle.
//   state  | meaning
//   IDLE   | waiting for start; operands captured on acceptance
//   LOAD   | r = 1 mod n, b = base mod n
//   ITER   | one exponent bit per cycle: conditional multiply, square, shift
//   DONE   | one-cycle done pulse, result valid
module mod_exp_unit
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         done,
  output logic         err
);
  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0] r_acc;
  logic [W-1:0] r_b;
  logic [W-1:0] r_e;
  logic [W-1:0] r_n;

  logic         w_load;
  logic [W-1:0] w_one;
  logic [W-1:0] w_mul_a;
  logic [W-1:0] w_sq_a;
  logic [W-1:0] w_sq_b;
  logic [W-1:0] w_mul_p;
  logic [W-1:0] w_sq_p;

  // In LOAD the two multipliers are reused to reduce base and 1 by n.
  assign w_one   = {{(W-1){1'b0}}, 1'b1};
  assign w_load  = (r_state == S_LOAD);
  assign w_mul_a = w_load ? w_one : r_acc;
  assign w_sq_a  = w_load ? w_one : r_b;
  assign w_sq_b  = w_load ? w_one : r_b;

  mod_mul #(.W(W)) u_mul (
    .i_a (w_mul_a),
    .i_b (r_b),
    .i_n (r_n),
    .o_p (w_mul_p)
  );

  mod_mul #(.W(W)) u_sq (
    .i_a (w_sq_a),
    .i_b (w_sq_b),
    .i_n (r_n),
    .o_p (w_sq_p)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = (r_e == '0 || r_n == '0) ? S_DONE : S_ITER;
      S_ITER:  if (r_e[W-1:1] == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_b    <= '0;
      r_e    <= '0;
      r_n    <= '0;
      result <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b <= base;
            r_e <= exp;
            r_n <= modulus;
            err <= 1'b0;
          end
        end
        S_LOAD: begin
          r_acc <= w_sq_p;
          r_b   <= w_mul_p;
          if (w_state_nxt == S_DONE) begin
            result <= w_sq_p;
            err    <= (r_n == '0);
          end
        end
        S_ITER: begin
          if (r_e[0]) r_acc <= w_mul_p;
          r_b <= w_sq_p;
          r_e <= r_e >> 1;
          // The last processed bit is the exponent MSB, so the final result is the fresh product.
          if (w_state_nxt == S_DONE) result <= r_e[0] ? w_mul_p : r_acc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_exp_unit.sv
// Scoreboard bench for mod_exp_unit: directed corner cases plus random triples vs a 64-bit model.
module tb_mod_exp_unit;
  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic [31:0] exp_in;
  logic [31:0] modulus;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  mod_exp_unit #(.W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .exp     (exp_in),
    .modulus (modulus),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                             input logic [31:0] n);
    logic [63:0] r, bb, nn;
    if (n == 0) return 32'd0;
    nn = {32'd0, n};
    r  = 64'd1 % nn;
    bb = {32'd0, b} % nn;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * bb) % nn;
      bb = (bb * bb) % nn;
    end
    return r[31:0];
  endfunction

  function automatic int bitlen(input logic [31:0] e);
    for (int i = 31; i >= 0; i--) if (e[i]) return i + 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // poke > 0 pulses start (with unrelated operands) that many cycles into the operation.
  task automatic run_op(input string tag, input logic [31:0] b, input logic [31:0] e,
                        input logic [31:0] n, input int poke);
    exp_t x;
    exp_t got;
    int   k;
    bit   seen;
    x.res = ref_modexp(b, e, n);
    x.err = (n == 0);
    x.lat = (n == 0 || e == 0) ? 1 : bitlen(e) + 1;
    sb.push_back(x);
    base = b; exp_in = e; modulus = n; start = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    base = $urandom; exp_in = $urandom; modulus = $urandom;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    k = 0; seen = 0;
    while (!seen && k < 80) begin
      start = (poke != 0 && k == poke);
      @(posedge clk); #1;
      k++;
      if (done) seen = 1;
    end
    start = 1'b0;
    got = sb.pop_front();
    chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      chk({tag, "_result"}, {32'd0, result}, {32'd0, got.res});
      chk({tag, "_err"}, {63'd0, err}, {63'd0, got.err});
      chk({tag, "_latency"}, 64'(k), 64'(got.lat));
      @(posedge clk); #1;
      chk({tag, "_done_drop"}, {62'd0, done, busy}, 64'd0);
      chk({tag, "_hold"}, {32'd0, result}, {32'd0, got.res});
    end
  endtask

  initial begin
    int   k;
    int   t1, t2, ndone;
    logic [31:0] rb, re, rn;

    rst = 1'b1; start = 1'b0; base = '0; exp_in = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);

    // rst drops in the same step start rises: first start is taken on the first low edge.
    run_op("req34", 32'd4, 32'd13, 32'd497, 0);
    chk("req34_const", {32'd0, result}, 64'd445);
    run_op("req35", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, 0);
    chk("req35_const", {32'd0, result}, 64'd16);
    run_op("exp0", 32'd9, 32'd0, 32'd7, 0);
    chk("exp0_const", {32'd0, result}, 64'd1);
    run_op("mod1", 32'd9, 32'd5, 32'd1, 0);
    run_op("mod0", 32'd5, 32'd3, 32'd0, 0);
    run_op("after_mod0", 32'd3, 32'd5, 32'd11, 0);
    run_op("big_base", 32'd1000, 32'd77, 32'd97, 0);
    run_op("poke", 32'd2, 32'h400, 32'd89, 3);

    // Reset mid-operation aborts without a done pulse.
    base = 32'd2; exp_in = 32'h400; modulus = 32'd89; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // start held high: the next operation is accepted in the IDLE cycle after DONE.
    base = 32'd4; exp_in = 32'd13; modulus = 32'd497; start = 1'b1;
    k = 0;
    while (!done && k < 40) begin @(posedge clk); #1; k++; end
    chk("b2b_first", {63'd0, done}, 64'd1);
    t1 = cyc;
    @(posedge clk); #1;
    k = 0;
    while (!done && k < 40) begin @(posedge clk); #1; k++; end
    chk("b2b_second", {63'd0, done}, 64'd1);
    t2 = cyc;
    chk("b2b_gap", 64'(t2 - t1), 64'd7);
    chk("b2b_result", {32'd0, result}, {32'd0, ref_modexp(32'd4, 32'd13, 32'd497)});
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      rb = $urandom;
      case ($urandom_range(0, 9))
        0:       rn = 32'd0;
        1:       rn = 32'd1;
        2, 3:    rn = $urandom_range(2, 255);
        default: rn = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       re = 32'd0;
        1, 2:    re = $urandom_range(1, 255);
        default: re = $urandom;
      endcase
      run_op("rand", rb, re, rn, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
